// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 32-bit CPU: captures the decoded bundle and operands,
// detects load-use hazards (bubble + IF/ID stall) and honours external flush and hold.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_src,
  input  logic [3:0]        id_alu_op,
  input  logic              id_pc_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [1:0]        id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic [RA_W-1:0]   id_rs1_addr,
  input  logic [RA_W-1:0]   id_rs2_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic              ex_pc_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [1:0]        ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic [RA_W-1:0]   ex_rs1_addr,
  output logic [RA_W-1:0]   ex_rs2_addr,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic              stall_ifid,
  output logic [15:0]       bubble_count
);

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic              r_valid_p1;
  logic [1:0]        r_alu_src_p1;
  logic [3:0]        r_alu_op_p1;
  logic              r_pc_src_p1;
  logic              r_mem_read_p1;
  logic              r_mem_write_p1;
  logic [1:0]        r_mem_to_reg_p1;
  logic              r_reg_write_p1;
  logic [RA_W-1:0]   r_rs1_addr_p1;
  logic [RA_W-1:0]   r_rs2_addr_p1;
  logic [RA_W-1:0]   r_rd_addr_p1;
  logic [DATA_W-1:0] r_rs1_data_p1;
  logic [DATA_W-1:0] r_rs2_data_p1;
  logic [DATA_W-1:0] r_imm_p1;
  logic [DATA_W-1:0] r_pc_plus4_p1;
  logic [CNT_W-1:0]  r_bubble_cnt_p1;

  logic              w_rs1_match;
  logic              w_rs2_match;
  logic              w_hazard;
  logic              w_bubble;
  logic              w_load;
  logic              w_count;
  logic [1:0]        w_alu_src_g;
  logic [3:0]        w_alu_op_g;
  logic              w_pc_src_g;
  logic              w_mem_read_g;
  logic              w_mem_write_g;
  logic [1:0]        w_mem_to_reg_g;
  logic              w_reg_write_g;

  // Only a load sitting in EX can produce a value too late for forwarding; r0 never does.
  assign w_rs1_match = (r_rd_addr_p1 == id_rs1_addr);
  assign w_rs2_match = (r_rd_addr_p1 == id_rs2_addr);
  assign w_hazard    = r_valid_p1 & r_mem_read_p1 & (r_rd_addr_p1 != '0) & id_valid
                       & (w_rs1_match | w_rs2_match);

  assign stall_ifid  = (w_hazard | hold) & ~flush;

  // Priority: flush, then hold, then hazard bubble, then normal load.
  assign w_bubble    = flush | (~hold & w_hazard);
  assign w_load      = ~flush & ~hold & ~w_hazard;
  assign w_count     = ~flush & ~hold & w_hazard;

  assign w_alu_src_g    = id_valid ? id_alu_src    : '0;
  assign w_alu_op_g     = id_valid ? id_alu_op     : '0;
  assign w_pc_src_g     = id_valid & id_pc_src;
  assign w_mem_read_g   = id_valid & id_mem_read;
  assign w_mem_write_g  = id_valid & id_mem_write;
  assign w_mem_to_reg_g = id_valid ? id_mem_to_reg : '0;
  assign w_reg_write_g  = id_valid & id_reg_write;

  // ID -> EX stage boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_p1      <= 1'b0;
      r_alu_src_p1    <= '0;
      r_alu_op_p1     <= '0;
      r_pc_src_p1     <= 1'b0;
      r_mem_read_p1   <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_mem_to_reg_p1 <= '0;
      r_reg_write_p1  <= 1'b0;
      r_rs1_addr_p1   <= '0;
      r_rs2_addr_p1   <= '0;
      r_rd_addr_p1    <= '0;
      r_rs1_data_p1   <= '0;
      r_rs2_data_p1   <= '0;
      r_imm_p1        <= '0;
      r_pc_plus4_p1   <= '0;
    end else if (w_bubble) begin
      r_valid_p1      <= 1'b0;
      r_alu_src_p1    <= '0;
      r_alu_op_p1     <= '0;
      r_pc_src_p1     <= 1'b0;
      r_mem_read_p1   <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_mem_to_reg_p1 <= '0;
      r_reg_write_p1  <= 1'b0;
      r_rs1_addr_p1   <= '0;
      r_rs2_addr_p1   <= '0;
      r_rd_addr_p1    <= '0;
      r_rs1_data_p1   <= '0;
      r_rs2_data_p1   <= '0;
      r_imm_p1        <= '0;
      r_pc_plus4_p1   <= '0;
    end else if (w_load) begin
      r_valid_p1      <= id_valid;
      r_alu_src_p1    <= w_alu_src_g;
      r_alu_op_p1     <= w_alu_op_g;
      r_pc_src_p1     <= w_pc_src_g;
      r_mem_read_p1   <= w_mem_read_g;
      r_mem_write_p1  <= w_mem_write_g;
      r_mem_to_reg_p1 <= w_mem_to_reg_g;
      r_reg_write_p1  <= w_reg_write_g;
      r_rs1_addr_p1   <= id_rs1_addr;
      r_rs2_addr_p1   <= id_rs2_addr;
      r_rd_addr_p1    <= id_rd_addr;
      r_rs1_data_p1   <= id_rs1_data;
      r_rs2_data_p1   <= id_rs2_data;
      r_imm_p1        <= id_imm;
      r_pc_plus4_p1   <= id_pc_plus4;
    end
  end

  // Flush bubbles are deliberately not counted; only hazard bubbles are.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt_p1 <= '0;
    end else if (w_count) begin
      r_bubble_cnt_p1 <= sat_inc(r_bubble_cnt_p1);
    end
  end

  assign ex_valid      = r_valid_p1;
  assign ex_alu_src    = r_alu_src_p1;
  assign ex_alu_op     = r_alu_op_p1;
  assign ex_pc_src     = r_pc_src_p1;
  assign ex_mem_read   = r_mem_read_p1;
  assign ex_mem_write  = r_mem_write_p1;
  assign ex_mem_to_reg = r_mem_to_reg_p1;
  assign ex_reg_write  = r_reg_write_p1;
  assign ex_rs1_addr   = r_rs1_addr_p1;
  assign ex_rs2_addr   = r_rs2_addr_p1;
  assign ex_rd_addr    = r_rd_addr_p1;
  assign ex_rs1_data   = r_rs1_data_p1;
  assign ex_rs2_data   = r_rs2_data_p1;
  assign ex_imm        = r_imm_p1;
  assign ex_pc_plus4   = r_pc_plus4_p1;
  assign bubble_count  = r_bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each EX slot and stall,
// expectations are queued when ID is driven and compared after the clock edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_src;
    logic [3:0]  alu_op;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc4;
  } slot_t;

  typedef struct {
    slot_t       st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        hold;
  slot_t       id_in;
  slot_t       ex_out;
  logic        stall_ifid;
  logic [15:0] bubble_count;

  slot_t       m;
  logic [15:0] m_cnt;
  exp_t        q[$];
  int          n_checks;
  int          n_err;

  id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_in.valid),
    .id_alu_src   (id_in.alu_src),
    .id_alu_op    (id_in.alu_op),
    .id_pc_src    (id_in.pc_src),
    .id_mem_read  (id_in.mem_read),
    .id_mem_write (id_in.mem_write),
    .id_mem_to_reg(id_in.mem_to_reg),
    .id_reg_write (id_in.reg_write),
    .id_rs1_addr  (id_in.rs1a),
    .id_rs2_addr  (id_in.rs2a),
    .id_rd_addr   (id_in.rda),
    .id_rs1_data  (id_in.rs1d),
    .id_rs2_data  (id_in.rs2d),
    .id_imm       (id_in.imm),
    .id_pc_plus4  (id_in.pc4),
    .flush        (flush),
    .hold         (hold),
    .ex_valid     (ex_out.valid),
    .ex_alu_src   (ex_out.alu_src),
    .ex_alu_op    (ex_out.alu_op),
    .ex_pc_src    (ex_out.pc_src),
    .ex_mem_read  (ex_out.mem_read),
    .ex_mem_write (ex_out.mem_write),
    .ex_mem_to_reg(ex_out.mem_to_reg),
    .ex_reg_write (ex_out.reg_write),
    .ex_rs1_addr  (ex_out.rs1a),
    .ex_rs2_addr  (ex_out.rs2a),
    .ex_rd_addr   (ex_out.rda),
    .ex_rs1_data  (ex_out.rs1d),
    .ex_rs2_data  (ex_out.rs2d),
    .ex_imm       (ex_out.imm),
    .ex_pc_plus4  (ex_out.pc4),
    .stall_ifid   (stall_ifid),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input slot_t e, input logic [15:0] c);
    check("ctl",  32'({ex_out.valid, ex_out.alu_src, ex_out.alu_op, ex_out.pc_src,
                       ex_out.mem_read, ex_out.mem_write, ex_out.mem_to_reg, ex_out.reg_write}),
                  32'({e.valid, e.alu_src, e.alu_op, e.pc_src,
                       e.mem_read, e.mem_write, e.mem_to_reg, e.reg_write}));
    check("addr", 32'({ex_out.rs1a, ex_out.rs2a, ex_out.rda}), 32'({e.rs1a, e.rs2a, e.rda}));
    check("rs1d", ex_out.rs1d, e.rs1d);
    check("rs2d", ex_out.rs2d, e.rs2d);
    check("imm",  ex_out.imm,  e.imm);
    check("pc4",  ex_out.pc4,  e.pc4);
    check("bcnt", 32'(bubble_count), 32'(c));
  endtask

  function automatic slot_t mk_alu(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd);
    slot_t e = '0;
    e.valid = 1'b1; e.alu_op = 4'h0; e.reg_write = 1'b1;
    e.rs1a = rs1; e.rs2a = rs2; e.rda = rd;
    e.rs1d = $urandom; e.rs2d = $urandom; e.pc4 = $urandom;
    return e;
  endfunction

  function automatic slot_t mk_lw(input logic [4:0] rs1, input logic [4:0] rd);
    slot_t e = '0;
    e.valid = 1'b1; e.alu_src = 2'd1; e.mem_read = 1'b1; e.mem_to_reg = 2'd1;
    e.reg_write = 1'b1; e.rs1a = rs1; e.rs2a = 5'd0; e.rda = rd;
    e.rs1d = $urandom; e.imm = 32'h4; e.pc4 = $urandom;
    return e;
  endfunction

  function automatic slot_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    slot_t e = '0;
    e.valid = 1'b1; e.alu_src = 2'd1; e.mem_write = 1'b1;
    e.rs1a = rs1; e.rs2a = rs2; e.rda = 5'd0;
    e.rs1d = $urandom; e.rs2d = $urandom; e.imm = 32'hFFFF_FFF8;
    return e;
  endfunction

  function automatic slot_t mk_jal(input logic [4:0] rd, input logic [31:0] pc4);
    slot_t e = '0;
    e.valid = 1'b1; e.alu_src = 2'd2; e.alu_op = 4'h3; e.pc_src = 1'b1;
    e.mem_to_reg = 2'd2; e.reg_write = 1'b1; e.rda = rd;
    e.imm = 32'h0000_0100; e.pc4 = pc4;
    return e;
  endfunction

  // Drive one ID cycle, check the combinational stall, predict EX, compare after the edge.
  task automatic step(input slot_t id, input logic fl, input logic hd);
    exp_t e;
    logic hz;
    @(negedge clk);
    id_in = id; flush = fl; hold = hd;
    #1;
    hz = m.valid & m.mem_read & (m.rda != 5'd0) & id.valid
         & ((m.rda == id.rs1a) | (m.rda == id.rs2a));
    check("stall", 32'(stall_ifid), 32'((hz | hd) & ~fl));
    if (fl) begin
      m = '0;
    end else if (!hd) begin
      if (hz) begin
        m = '0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m = id;
        if (!id.valid) begin
          m.alu_src = '0; m.alu_op = '0; m.pc_src = 1'b0; m.mem_read = 1'b0;
          m.mem_write = 1'b0; m.mem_to_reg = '0; m.reg_write = 1'b0;
        end
      end
    end
    e.st = m; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = q.pop_front();
      check_all(e.st, e.cnt);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    slot_t t;
    n_checks = 0; n_err = 0;
    m = '0; m_cnt = '0;
    reset = 1'b1; flush = 1'b0; hold = 1'b0; id_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check_all('0, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Passthrough ADD
    t = mk_alu(5'd3, 5'd4, 5'd5); t.rs1d = 32'h11; t.rs2d = 32'h22;
    step(t, 1'b0, 1'b0);

    // Load-use on rs2: one bubble, then the held ADD advances
    step(mk_lw(5'd1, 5'd7), 1'b0, 1'b0);
    t = mk_alu(5'd2, 5'd7, 5'd8);
    step(t, 1'b0, 1'b0);
    step(t, 1'b0, 1'b0);

    // r0 destination never stalls
    step(mk_lw(5'd2, 5'd0), 1'b0, 1'b0);
    step(mk_alu(5'd0, 5'd5, 5'd9), 1'b0, 1'b0);

    // Flush beats hazard, not counted
    step(mk_lw(5'd3, 5'd9), 1'b0, 1'b0);
    step(mk_alu(5'd9, 5'd1, 5'd10), 1'b1, 1'b0);

    // Hold freezes a JAL for three cycles
    step(mk_jal(5'd1, 32'h0000_0104), 1'b0, 1'b0);
    t = mk_alu(5'd4, 5'd5, 5'd6);
    repeat (3) step(t, 1'b0, 1'b1);
    step(t, 1'b0, 1'b0);

    // Store data dependent on a load stalls; ALU producer does not
    step(mk_lw(5'd3, 5'd12), 1'b0, 1'b0);
    t = mk_sw(5'd1, 5'd12);
    step(t, 1'b0, 1'b0);
    step(t, 1'b0, 1'b0);
    step(mk_alu(5'd1, 5'd2, 5'd13), 1'b0, 1'b0);
    step(mk_alu(5'd13, 5'd13, 5'd14), 1'b0, 1'b0);

    // Hold together with a hazard: hold wins, then the hazard bubble is counted
    step(mk_lw(5'd3, 5'd15), 1'b0, 1'b0);
    t = mk_alu(5'd15, 5'd1, 5'd2);
    step(t, 1'b0, 1'b1);
    step(t, 1'b0, 1'b0);
    step(t, 1'b0, 1'b0);

    // Invalid ID instruction: control forced to zero, no hazard even on a matching rs1
    step(mk_lw(5'd3, 5'd7), 1'b0, 1'b0);
    t = mk_jal(5'd9, 32'h0000_0200); t.valid = 1'b0; t.rs1a = 5'd7;
    step(t, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with a valid ADD in EX
    step(mk_alu(5'd3, 5'd4, 5'd5), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    m = '0; m_cnt = '0;
    check_all('0, 16'h0);
    id_in = '0;
    @(negedge clk);
    reset = 1'b0;

    // Saturation: preload the counter, then force a load-use
    force dut.r_bubble_cnt_p1 = 16'hFFFF;
    #1;
    release dut.r_bubble_cnt_p1;
    m_cnt = 16'hFFFF;
    step(mk_lw(5'd1, 5'd20), 1'b0, 1'b0);
    t = mk_alu(5'd20, 5'd20, 5'd21);
    step(t, 1'b0, 1'b0);
    step(t, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
